// File: rtl/fp_apu_arbiter.sv
// Shares one fp_wrapper APU port among NUM_REQ requesters: round-robin (or fixed-priority
// when FP_ARB_FIXED_PRIO_EN is defined) arbitration with lock-until-grant, in-order tag FIFO routing.
module fp_apu_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned FLAGS_W   = 11
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  input  logic [NUM_REQ-1:0][2:0][31:0]      operands_i,
  input  logic [NUM_REQ-1:0][5:0]            op_i,
  input  logic [NUM_REQ-1:0][FLAGS_W-1:0]    flags_i,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [31:0]                        rdata_o,
  output logic [4:0]                         rflags_o,
  output logic                               apu_req_o,
  input  logic                               apu_gnt_i,
  output logic [2:0][31:0]                   apu_operands_o,
  output logic [5:0]                         apu_op_o,
  output logic [FLAGS_W-1:0]                 apu_flags_o,
  input  logic                               apu_rvalid_i,
  input  logic [31:0]                        apu_rdata_i,
  input  logic [4:0]                         apu_rflags_i,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                win_q, win_d;
  logic [IDX_W-1:0]                arb_win, winner, idx_w;
  logic [TAG_DEPTH-1:0][IDX_W-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic                            apu_req, hs, push, pop, fifo_full, fifo_empty;

`ifdef FP_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; iterate downward so the lowest overwrites last.
  always_comb begin
    arb_win = '0;
    idx_w   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_w = IDX_W'(i);
      if (req_i[idx_w]) arb_win = idx_w;
    end
  end
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             found;
  int unsigned      idx;

  // First asserted request at or after the RR pointer, wrapping modulo NUM_REQ.
  always_comb begin
    arb_win = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx   = (32'(rr_q) + i) % NUM_REQ;
      idx_w = IDX_W'(idx);
      if (!found && req_i[idx_w]) begin
        found   = 1'b1;
        arb_win = idx_w;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  assign fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Lock FSM: a request that is not granted immediately pins its winner.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    winner  = arb_win;
    apu_req = 1'b0;
    case (state_q)
      IDLE: begin
        apu_req = (|req_i) & ~fifo_full;
        if (apu_req && !apu_gnt_i) begin
          state_d = LOCKED;
          win_d   = arb_win;
        end
      end
      LOCKED: begin
        winner  = win_q;
        apu_req = ~fifo_full;
        if (apu_req && apu_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs   = apu_req & apu_gnt_i;
  assign push = hs;
  assign pop  = apu_rvalid_i & ~fifo_empty;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[winner]             = 1'b1;
    if (pop) rvalid_o[tags_q[rd_ptr_q]] = 1'b1;
  end

  assign apu_req_o      = apu_req;
  assign apu_operands_o = apu_req ? operands_i[winner] : '0;
  assign apu_op_o       = apu_req ? op_i[winner]       : '0;
  assign apu_flags_o    = apu_req ? flags_i[winner]    : '0;
  assign rdata_o        = apu_rdata_i;
  assign rflags_o       = apu_rflags_i;
  assign busy_o         = ~fifo_empty;
  assign err_o          = err_q;

  // Tag FIFO: responses come back in issue order, so the head names the target.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q | (apu_rvalid_i & fifo_empty);
    if (push) begin
      tags_d[wr_ptr_q] = winner;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      win_q    <= '0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fp_apu_arbiter.sv
// Directed bench for fp_apu_arbiter (default round-robin build, NUM_REQ=2, TAG_DEPTH=4).
module tb_fp_apu_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned FLAGS_W = 11;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic [NUM_REQ-1:0]              req_i;
  logic [NUM_REQ-1:0]              gnt_o;
  logic [NUM_REQ-1:0][2:0][31:0]   operands_i;
  logic [NUM_REQ-1:0][5:0]         op_i;
  logic [NUM_REQ-1:0][FLAGS_W-1:0] flags_i;
  logic [NUM_REQ-1:0]              rvalid_o;
  logic [31:0]                     rdata_o;
  logic [4:0]                      rflags_o;
  logic                            apu_req_o;
  logic                            apu_gnt_i;
  logic [2:0][31:0]                apu_operands_o;
  logic [5:0]                      apu_op_o;
  logic [FLAGS_W-1:0]              apu_flags_o;
  logic                            apu_rvalid_i;
  logic [31:0]                     apu_rdata_i;
  logic [4:0]                      apu_rflags_i;
  logic                            busy_o;
  logic                            err_o;

  fp_apu_arbiter #(.NUM_REQ(2), .TAG_DEPTH(4), .FLAGS_W(11)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .operands_i(operands_i), .op_i(op_i), .flags_i(flags_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rflags_o(rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
    .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o), .apu_rvalid_i(apu_rvalid_i),
    .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic        e_apu_req;
    logic [5:0]  e_op;
    logic [1:0]  e_rvalid;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    req_i        = req;
    apu_gnt_i    = gnt;
    apu_rvalid_i = rv;
    apu_rdata_i  = rd;
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    operands_i[0] = {32'h40200000, 32'h40200000, 32'h40200000};
    operands_i[1] = {32'h3F800000, 32'h40000000, 32'h40400000};
    op_i[0]       = 6'h02;
    op_i[1]       = 6'h05;
    flags_i[0]    = 11'h001;
    flags_i[1]    = 11'h602;
    apu_rflags_i  = 5'h00;

    //            req    gnt   rv    rdata          gnt    areq  op     rvalid busy  err
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 6'h02, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 1'b0, 1'b1, 32'h40C80000, 2'b00, 1'b0, 6'h00, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 6'h05, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 6'h02, 2'b00, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 6'h05, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 6'h02, 2'b00, 1'b1, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h00, 2'b00, 1'b1, 1'b0};
    vecs[8]  = '{2'b11, 1'b1, 1'b1, 32'h11111111, 2'b00, 1'b0, 6'h00, 2'b10, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 1'b1, 1'b1, 32'h22222222, 2'b10, 1'b1, 6'h05, 2'b01, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 32'h33333333, 2'b00, 1'b0, 6'h00, 2'b10, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 1'b1, 32'h44444444, 2'b00, 1'b0, 6'h00, 2'b01, 1'b1, 1'b0};
    vecs[12] = '{2'b00, 1'b0, 1'b1, 32'h55555555, 2'b00, 1'b0, 6'h00, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{2'b00, 1'b0, 1'b1, 32'h66666666, 2'b00, 1'b0, 6'h00, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h00, 2'b00, 1'b0, 1'b1};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      settle();
      chk($sformatf("v%0d gnt_o", i),     64'(gnt_o),     64'(vecs[i].e_gnt));
      chk($sformatf("v%0d apu_req_o", i), 64'(apu_req_o), 64'(vecs[i].e_apu_req));
      chk($sformatf("v%0d apu_op_o", i),  64'(apu_op_o),  64'(vecs[i].e_op));
      chk($sformatf("v%0d rvalid_o", i),  64'(rvalid_o),  64'(vecs[i].e_rvalid));
      chk($sformatf("v%0d busy_o", i),    64'(busy_o),    64'(vecs[i].e_busy));
      chk($sformatf("v%0d err_o", i),     64'(err_o),     64'(vecs[i].e_err));
      chk($sformatf("v%0d rdata_o", i),   64'(rdata_o),   64'(vecs[i].rdata));
      if (i == 1) begin
        chk("v1 operands", 64'(apu_operands_o[0]), 64'h40200000);
        chk("v1 flags",    64'(apu_flags_o),       64'h001);
      end
      if (i == 3) chk("v3 operand2", 64'(apu_operands_o[2]), 64'h3F800000);
      advance();
    end

    // Sticky error survives idle cycles and clears only on reset.
    apu_rflags_i = 5'h15;
    advance();
    advance();
    settle();
    chk("err sticky", 64'(err_o), 64'h1);
    chk("rflags pass", 64'(rflags_o), 64'h15);
    advance();
    do_reset();
    settle();
    chk("err cleared", 64'(err_o), 64'h0);
    advance();

    // Round-robin from reset with both requesting, then in-order response routing.
    begin
      logic [1:0] exp_seq [4];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      for (int k = 0; k < 4; k++) begin
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        settle();
        chk($sformatf("rr gnt%0d", k), 64'(gnt_o), 64'(exp_seq[k]));
        advance();
      end
      for (int k = 0; k < 4; k++) begin
        drive(2'b00, 1'b0, 1'b1, 32'hA0000000 + 32'(k));
        settle();
        chk($sformatf("rr rvalid%0d", k), 64'(rvalid_o), 64'(exp_seq[k]));
        advance();
      end
    end

    // Reset with an op outstanding; the stale response then flags an error.
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    settle();
    chk("pre-reset gnt", 64'(gnt_o), 64'h1);
    advance();
    settle();
    chk("pre-reset busy", 64'(busy_o), 64'h1);
    do_reset();
    settle();
    chk("post-reset busy", 64'(busy_o), 64'h0);
    advance();
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD0000);
    settle();
    chk("stale rvalid", 64'(rvalid_o), 64'h0);
    advance();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    chk("stale err", 64'(err_o), 64'h1);
    do_reset();

    // Stall: requester 0 locked through no-grant cycles, newer and dropped requests ignored.
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      settle();
      chk($sformatf("stall%0d req", k), 64'(apu_req_o), 64'h1);
      chk($sformatf("stall%0d gnt", k), 64'(gnt_o), 64'h0);
      advance();
    end
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    settle();
    chk("stall both op", 64'(apu_op_o), 64'h02);
    advance();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    chk("stall drop req", 64'(apu_req_o), 64'h1);
    chk("stall drop op", 64'(apu_op_o), 64'h02);
    advance();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    chk("stall gnt0", 64'(gnt_o), 64'h1);
    advance();
    settle();
    chk("stall gnt1", 64'(gnt_o), 64'h2);
    chk("stall op1", 64'(apu_op_o), 64'h05);
    advance();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
